// File: rtl/retire_trace_pkg.sv
// Shared types for the retirement tracker: shadow-stage pair and trace record.
package retire_trace_pkg;

   localparam int unsigned PC_W       = 8;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned RA_W       = 3;
   localparam int unsigned TS_W       = 16;
   localparam int unsigned RETIRE_LAT = 4;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            valid;
   } stage_t;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic              we;
      logic [RA_W-1:0]   addr;
      logic [DATA_W-1:0] data;
      logic [TS_W-1:0]   ts;
   } trace_rec_t;

endpackage

// File: rtl/retire_trace_unit_fifo.sv
// Synchronous FIFO of trace records; head read straight from the storage flops.
module trace_fifo
   import retire_trace_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic       pop_i,
   input  trace_rec_t wdata_i,
   output trace_rec_t rdata_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   trace_rec_t  mem_q [DEPTH];
   logic        wr_en;
   logic        rd_en;

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign wr_en   = push_i && (!full_o || pop_i);
   assign rd_en   = pop_i && !empty_o;
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/retire_trace_unit.sv
// Shadows the core pipeline with a PC/valid chain and logs each WB retirement
// as a timestamped record into a small trace FIFO.
module retire_trace_unit
   import retire_trace_pkg::*;
#(
   parameter int unsigned PC_WIDTH   = PC_W,
   parameter int unsigned DATA_WIDTH = DATA_W,
   parameter int unsigned RA_WIDTH   = RA_W,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned TS_WIDTH   = TS_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PC_WIDTH-1:0]   pc,
   input  logic                  pipeline_stall_n,
   input  logic                  branch_taken,
   input  logic                  wb_we,
   input  logic [RA_WIDTH-1:0]   wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  trace_valid,
   input  logic                  trace_ready,
   output logic [PC_WIDTH-1:0]   trace_pc,
   output logic                  trace_we,
   output logic [RA_WIDTH-1:0]   trace_addr,
   output logic [DATA_WIDTH-1:0] trace_data,
   output logic [TS_WIDTH-1:0]   trace_ts,
   output logic                  overflow,
   output logic [31:0]           retire_count
);

   // Index 0 is ID, RETIRE_LAT-1 is WB.
   stage_t                chain_q [RETIRE_LAT];
   stage_t                chain_d [RETIRE_LAT];
   logic [TS_WIDTH-1:0]   ts_q, ts_d;
   logic [31:0]           count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  retire;
   logic                  pop;
   logic                  full;
   logic                  empty;
   trace_rec_t            rec;
   trace_rec_t            head;

   always_comb begin
      if (branch_taken) begin
         chain_d[0] = '0;
         chain_d[1] = '0;
      end else if (!pipeline_stall_n) begin
         chain_d[0] = chain_q[0];
         chain_d[1] = '0;
      end else begin
         chain_d[0] = {pc, 1'b1};
         chain_d[1] = chain_q[0];
      end
      for (int i = 2; i < RETIRE_LAT; i++) chain_d[i] = chain_q[i-1];
   end

   assign retire = chain_q[RETIRE_LAT-1].valid;
   assign pop    = trace_valid && trace_ready;

   always_comb begin
      rec        = '{pc: chain_q[RETIRE_LAT-1].pc, we: wb_we, addr: wb_addr, data: wb_data,
                     ts: ts_q};
      ts_d       = ts_q + 1'b1;
      count_d    = retire ? count_q + 32'd1 : count_q;
      overflow_d = overflow_q | (retire && full && !pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RETIRE_LAT; i++) chain_q[i] <= '0;
         ts_q       <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         for (int i = 0; i < RETIRE_LAT; i++) chain_q[i] <= chain_d[i];
         ts_q       <= ts_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   trace_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (retire),
      .pop_i   (pop),
      .wdata_i (rec),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign trace_valid  = !empty;
   assign trace_pc     = head.pc;
   assign trace_we     = head.we;
   assign trace_addr   = head.addr;
   assign trace_data   = head.data;
   assign trace_ts     = head.ts;
   assign overflow     = overflow_q;
   assign retire_count = count_q;

endmodule

// File: tb/tb_retire_trace_unit.sv
// Directed and randomized bench for retire_trace_unit against an instruction-level
// retirement schedule and a queue-based trace buffer model.
module tb_retire_trace_unit;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  pc = '0;
   logic        pipeline_stall_n = 1'b1;
   logic        branch_taken = 1'b0;
   logic        wb_we = 1'b0;
   logic [2:0]  wb_addr = '0;
   logic [15:0] wb_data = '0;
   logic        trace_valid;
   logic        trace_ready = 1'b0;
   logic [7:0]  trace_pc;
   logic        trace_we;
   logic [2:0]  trace_addr;
   logic [15:0] trace_data;
   logic [15:0] trace_ts;
   logic        overflow;
   logic [31:0] retire_count;

   retire_trace_unit dut (
      .clk              (clk),
      .rst              (rst),
      .pc               (pc),
      .pipeline_stall_n (pipeline_stall_n),
      .branch_taken     (branch_taken),
      .wb_we            (wb_we),
      .wb_addr          (wb_addr),
      .wb_data          (wb_data),
      .trace_valid      (trace_valid),
      .trace_ready      (trace_ready),
      .trace_pc         (trace_pc),
      .trace_we         (trace_we),
      .trace_addr       (trace_addr),
      .trace_data       (trace_data),
      .trace_ts         (trace_ts),
      .overflow         (overflow),
      .retire_count     (retire_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  pc;
      logic        we;
      logic [2:0]  addr;
      logic [15:0] data;
      logic [15:0] ts;
   } rec_t;

   int          errors = 0;
   int          checks = 0;

   // Model: the instruction waiting in ID, instructions scheduled to retire, trace buffer.
   int          t;
   bit          id_occ;
   logic [7:0]  id_pc;
   int          pend_cyc[$];
   logic [7:0]  pend_pc[$];
   rec_t        mq[$];
   bit          m_ovf;
   logic [31:0] m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      t      = 0;
      id_occ = 1'b0;
      id_pc  = '0;
      pend_cyc.delete();
      pend_pc.delete();
      mq.delete();
      m_ovf  = 1'b0;
      m_cnt  = '0;
   endtask

   // Applies the effect of the clock edge closing cycle t, using the inputs now driven.
   task automatic model_edge();
      bit   ret;
      bit   popm;
      bit   accept;
      rec_t r;
      ret    = (pend_cyc.size() > 0) && (pend_cyc[0] == t);
      popm   = trace_ready && (mq.size() > 0);
      accept = (mq.size() < DEPTH) || popm;
      if (popm) void'(mq.pop_front());
      if (ret) begin
         void'(pend_cyc.pop_front());
         r.pc   = pend_pc.pop_front();
         r.we   = wb_we;
         r.addr = wb_addr;
         r.data = wb_data;
         r.ts   = 16'(t);
         m_cnt  = m_cnt + 1;
         if (accept) mq.push_back(r);
         else m_ovf = 1'b1;
      end
      // An instruction leaving ID at edge t is in WB during cycle t+3.
      if (branch_taken) begin
         id_occ = 1'b0;
      end else if (pipeline_stall_n) begin
         if (id_occ) begin
            pend_cyc.push_back(t + 3);
            pend_pc.push_back(id_pc);
         end
         id_occ = 1'b1;
         id_pc  = pc;
      end
      t++;
   endtask

   task automatic check_outputs();
      chk("trace_valid", 32'(trace_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("trace_pc", 32'(trace_pc), 32'(mq[0].pc));
         chk("trace_we", 32'(trace_we), 32'(mq[0].we));
         chk("trace_addr", 32'(trace_addr), 32'(mq[0].addr));
         chk("trace_data", 32'(trace_data), 32'(mq[0].data));
         chk("trace_ts", 32'(trace_ts), 32'(mq[0].ts));
      end
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("retire_count", retire_count, m_cnt);
   endtask

   // Called at a falling edge: check state, drive cycle inputs, model the next edge.
   task automatic step(input logic st_n, input logic br, input logic rdy, input logic [7:0] p);
      check_outputs();
      pipeline_stall_n = st_n;
      branch_taken     = br;
      trace_ready      = rdy;
      pc               = p;
      wb_we            = 1'($urandom);
      wb_addr          = 3'($urandom);
      wb_data          = 16'($urandom);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      #1 rst = 1'b1;
      #1;
      chk("rst_async_valid", 32'(trace_valid), 32'd0);
      chk("rst_async_count", retire_count, 32'd0);
      chk("rst_async_ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_valid", 32'(trace_valid), 32'd0);
      chk("reset_pc", 32'(trace_pc), 32'd0);
      chk("reset_we", 32'(trace_we), 32'd0);
      chk("reset_addr", 32'(trace_addr), 32'd0);
      chk("reset_data", 32'(trace_data), 32'd0);
      chk("reset_ts", 32'(trace_ts), 32'd0);
      chk("reset_ovf", 32'(overflow), 32'd0);
      chk("reset_count", retire_count, 32'd0);
      rst = 1'b0;

      // Straight line, then a one-cycle stall with PC 3 in ID.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'(i));
      step(1'b0, 1'b0, 1'b1, 8'd4);
      chk("first_pc", 32'(trace_pc), 32'd0);
      chk("first_ts", 32'(trace_ts), 32'd4);
      step(1'b1, 1'b0, 1'b1, 8'd4);
      step(1'b1, 1'b0, 1'b1, 8'd5);
      // Branch in EX (PC 4) squashes 5 in ID and 6 in IF; target is 40.
      step(1'b1, 1'b1, 1'b1, 8'd6);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 8'(40 + i));

      // Overflow: ten retirements with nobody draining.
      do_reset();
      for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, 8'(100 + i));
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_count", retire_count, 32'd10);
      chk("ovf_head", 32'(trace_pc), 32'd100);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 8'd0);

      // Full FIFO with a pop in the same cycle as a retirement.
      do_reset();
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 8'(150 + i));
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 8'(162 + i));
      chk("fullpop_no_ovf", 32'(overflow), 32'd0);

      // Mid-run reset with three records buffered.
      do_reset();
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 8'(200 + i));
      chk("buffered_head", 32'(trace_pc), 32'd200);
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 8'(60 + i));
      chk("post_reset_pc", 32'(trace_pc), 32'd60);
      chk("post_reset_ts", 32'(trace_ts), 32'd4);

      // Randomized traffic, including back-pressure bursts and stall/flush overlap.
      for (int i = 0; i < 800; i++) begin
         logic st_n, br, rdy;
         st_n = ($urandom_range(0, 4) != 0);
         br   = ($urandom_range(0, 6) == 0);
         rdy  = ((i / 40) % 3 == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
         step(st_n, br, rdy, 8'($urandom));
      end
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 8'(i));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/retire_trace_unit.md
# retire_trace_unit

Synthesizable retirement tracker that sits directly downstream of `mips_16_core_top`, on the same `clk`/`rst` as the core. It shadows the core pipeline with a PC/valid shift chain, driven by the core's stall and branch-flush controls, so that every instruction reaching WB is paired with its fetch PC. Each retirement is pushed as a timestamped record into a small FIFO, which is drained by the bench scoreboard or by `reg_saver` over a valid/ready handshake.

## Interface
- `PC_WIDTH`, 8: core PC width; matches `` `PC_WIDTH ``.
- `DATA_WIDTH`, 16: register write-back data width.
- `RA_WIDTH`, 3: register address width (8 registers).
- `DEPTH`, 8: FIFO entries; must be a power of two, at least 2.
- `TS_WIDTH`, 16: cycle-timestamp width.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-high reset.
- `pc` in PC_WIDTH: core IF-stage PC. A fetch is sampled every cycle when not stalled.
- `pipeline_stall_n` in 1: low means IF and ID hold and a bubble enters EX.
- `branch_taken` in 1: high means a branch in EX squashes the IF and ID instructions.
- `wb_we` in 1: WB-stage register write enable.
- `wb_addr` in RA_WIDTH: WB destination register.
- `wb_data` in DATA_WIDTH: WB write data.
- `trace_valid` out 1: FIFO head is valid.
- `trace_ready` in 1: consumer accepts the head.
- `trace_pc` out PC_WIDTH: PC field of the head record.
- `trace_we` out 1: write-enable field of the head record.
- `trace_addr` out RA_WIDTH: register-address field of the head record.
- `trace_data` out DATA_WIDTH: write-data field of the head record.
- `trace_ts` out TS_WIDTH: timestamp field of the head record.
- `overflow` out 1: sticky; set when a retirement is dropped.
- `retire_count` out 32: total retirements observed, including dropped ones.

## Operation
- Shadow chain has four stages: `id`, `ex`, `mem`, `wb`. Each stage holds a `{pc, valid}` pair.
- IF capture: `id` loads `{pc, 1}` unless stalled.
- Normal cycle: every stage shifts one step forward.
- Stall (`pipeline_stall_n`=0):
  - `id` holds its contents.
  - `ex` loads a bubble (valid=0).
  - `mem` and `wb` keep shifting.
- Flush (`branch_taken`=1):
  - `id` loads valid=0.
  - `ex` loads valid=0.
  - `mem` and `wb` keep shifting.
  - Flush has priority over stall.
- Retire event: `wb.valid`=1 in a cycle.
  - Record pushed = {wb.pc, wb_we, wb_addr, wb_data, ts}.
  - `ts` is a free-running cycle counter. It starts at 0 after reset and wraps modulo 2^TS_WIDTH.
  - A bubble in WB pushes nothing.
- FIFO push/pop:
  - Pop occurs when `trace_valid && trace_ready`.
  - When full, a push is accepted only if a pop occurs in the same cycle.
  - Otherwise the record is dropped and `overflow` is set; it stays set until reset.
- `retire_count` increments on every retire event, dropped or not, and wraps at 2^32.
- Pointers are log2(DEPTH)+1 bits wide. Full/empty are derived from the MSB comparison of the two pointers.

## Timing
- Reset values:
  - All stage valid bits = 0.
  - Stage PCs = 0.
  - FIFO empty, so `trace_valid`=0.
  - All `trace_*` outputs = 0.
  - `overflow`=0, `retire_count`=0, `ts`=0.
- Pipeline latency, no stalls: a PC sampled at edge n retires in the WB cycle n+4. It is pushed at edge n+4, and `trace_valid` rises in cycle n+5 (FIFO write-to-read latency of 1).
- The FIFO head is registered. Outputs stay stable while `trace_valid && !trace_ready`.
- Reset asserted mid-operation clears every state element asynchronously. In-flight and buffered records are lost, and `overflow` is not set for them.
- Empty FIFO with a simultaneous push and pop: the record is not bypassed and appears on the next cycle.

## Structure
- Package `retire_trace_pkg`:
  - typedef `trace_rec_t` (packed struct: pc, we, addr, data, ts).
  - typedef `stage_t` ({pc, valid}).
  - localparam `RETIRE_LAT` = 4.
- Sub-module `trace_fifo`: a parameterised synchronous FIFO of `trace_rec_t` with push/pop/full/empty ports. The top level holds the shadow chain, timestamp counter, retire counter and overflow logic.

## Test plan
- Straight-line run: PCs 0,1,2 fetched at cycles 0–2 with `trace_ready`=1 → records pc=0,1,2 appear on cycles 5,6,7 with ts=4,5,6.
- Stall: `pipeline_stall_n`=0 for one cycle while PC 3 is in ID → the trace shows pc=3 exactly once, one cycle late, and no record for the bubble.
- Branch: `branch_taken`=1 while PCs 5 and 6 are in IF and ID → no records for 5 or 6; the next record is the branch target.
- Overflow: `trace_ready`=0 for 10 retirements with DEPTH=8 → 8 records kept (first 8 PCs), `overflow`=1, `retire_count`=10.
- Full with simultaneous pop: FIFO full, `trace_ready`=1 during a retire → push accepted, `overflow` stays 0, occupancy stays 8.
- Mid-run reset: assert `rst` with 3 records buffered → `trace_valid`=0 immediately, `retire_count`=0, and the first record after release has ts=4.
